mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port 8-bit memory between two requesters, requester 0 and requester 1.
- The memory is driven on the address, chip_en, read_write, data_in and data_out signals of the memory bus interface.
- Arbitration is round-robin; each requester uses a valid/ready request handshake, and reads return data on a one-cycle rvalid pulse.
- Sits between the memory port and its bus masters. Only one memory operation is outstanding at a time.

Parameters:
- RD_LATENCY, 1, cycles from the chip_en cycle of a read until mem_data_out is valid; legal range 1..4.

Ports:
- clock  input  1  single clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- r0_valid  input  1  requester 0 has a request pending
- r0_ready  output  1  request 0 accepted this cycle
- r0_write  input  1  1 = write, 0 = read
- r0_addr  input  8  request address
- r0_wdata  input  8  write data
- r0_rvalid  output  1  one-cycle pulse: r0_rdata is valid
- r0_rdata  output  8  read data
- r1_valid, r1_ready, r1_write, r1_addr, r1_wdata, r1_rvalid, r1_rdata: identical to the r0_* set, for requester 1
- mem_address  output  8  memory address
- mem_chip_en  output  1  memory enable, one cycle per operation
- mem_read_write  output  1  1 = write, 0 = read
- mem_data_in  output  8  write data to the memory
- mem_data_out  input  8  read data from the memory

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; priority pointer favours requester 0; latency counter = 0.
- Reset is synchronous and aborts any operation in flight. No rvalid is issued for an aborted read, and mem_chip_en is 0 from the first cycle after the reset edge.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE, arbitration:
  - rN_ready is combinational and is 1 only in IDLE, only for the arbitration winner.
  - One valid requester: it wins.
  - Both valid: the requester named by the priority pointer wins.
  - Handshake = valid && ready. On the handshake edge:
    - capture write, addr, wdata and the owner ID;
    - point the priority pointer at the other requester;
    - go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE, exactly one cycle:
  - mem_chip_en = 1; mem_address = captured address; mem_read_write = captured write; mem_data_in = captured wdata. All are registered outputs.
  - Write: next state is IDLE.
  - Read: next state is WAIT_RD; load the counter with RD_LATENCY.
- WAIT_RD:
  - mem_chip_en = 0; the counter decrements each cycle.
  - mem_data_out is valid in the cycle where chip_en cycle + RD_LATENCY is reached. At that edge, register mem_data_out into the owner's rdata and go to IDLE.
  - The owner's rvalid is 1 for exactly the next cycle, which is also an IDLE cycle where a new grant may occur.
- Latency, with H = handshake cycle:
  - chip_en at H+1;
  - read rvalid at H+2+RD_LATENCY;
  - a write occupies the memory for 2 cycles (H, H+1), so the next grant is possible at H+2.
- Idle bus values: when mem_chip_en = 0, mem_read_write is forced to 0. mem_address and mem_data_in hold their last values.
- Read data hold: rN_rdata holds its last read value until that requester's next read completes. The other requester's rvalid and rdata are unaffected.
- Requester rule (checked by a bench assertion): while valid = 1 and ready = 0, the requester holds write, addr and wdata stable.
- Edge cases:
  - No reordering.
  - Address wrap 0xFF is passed through unmodified.
  - A requester dropping valid before ready is not an error; no operation occurs.

Test Plan:
- Reset held 2 cycles with both valid high -> all outputs 0 during reset; first grant after release goes to r0.
- Write from r0, addr 0x10, wdata 0xA5 -> r0_ready at H. At H+1: mem_chip_en = 1, mem_read_write = 1, mem_address = 0x10, mem_data_in = 0xA5. At H+2: mem_chip_en = 0, mem_read_write = 0.
- Read from r1, addr 0x10, RD_LATENCY = 1, memory model returns 0xA5 -> r1_rvalid = 1 only at H+3 with r1_rdata = 0xA5; r0_rvalid stays 0.
- r0 and r1 both holding valid for 4 writes each -> grant order r0, r1, r0, r1, ...; a chip_en pulse every 2 cycles; addresses/data match their owners.
- RD_LATENCY = 3, read from r0, addr 0xFF, model returns 0x3C -> chip_en at H+1, r0_rvalid at H+5 with r0_rdata = 0x3C. r1_valid asserted during WAIT_RD is not granted until that rvalid cycle.
- Reset asserted during WAIT_RD of an r1 read -> no r1_rvalid ever pulses for it; chip_en = 0; the next simultaneous request is granted to r0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port 8-bit memory between two
// valid/ready requesters; one memory operation outstanding at a time.
module mem_port_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic       r0_write,
  input  logic [7:0] r0_addr,
  input  logic [7:0] r0_wdata,
  output logic       r0_rvalid,
  output logic [7:0] r0_rdata,
  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic       r1_write,
  input  logic [7:0] r1_addr,
  input  logic [7:0] r1_wdata,
  output logic       r1_rvalid,
  output logic [7:0] r1_rdata,
  output logic [7:0] mem_address,
  output logic       mem_chip_en,
  output logic       mem_read_write,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out
);

  // state   | meaning
  // IDLE    | arbitrate, grant at most one requester
  // ISSUE   | chip_en cycle for the captured operation
  // WAIT_RD | count down read latency, then deliver rdata
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t     state;
  logic       prio;
  logic       owner;
  logic [2:0] lat_cnt;
  logic       gnt0;
  logic       gnt1;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (r0_valid && (!r1_valid || !prio)) gnt0 = 1'b1;
      else if (r1_valid)                    gnt1 = 1'b1;
    end
  end

  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;
  assign req_write = gnt1 ? r1_write : r0_write;
  assign req_addr  = gnt1 ? r1_addr  : r0_addr;
  assign req_wdata = gnt1 ? r1_wdata : r0_wdata;

  // The memory bus registers double as the captured request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      prio           <= 1'b0;
      owner          <= 1'b0;
      lat_cnt        <= 3'd0;
      mem_address    <= 8'h00;
      mem_chip_en    <= 1'b0;
      mem_read_write <= 1'b0;
      mem_data_in    <= 8'h00;
      r0_rvalid      <= 1'b0;
      r0_rdata       <= 8'h00;
      r1_rvalid      <= 1'b0;
      r1_rdata       <= 8'h00;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            owner          <= gnt1;
            prio           <= gnt0;
            mem_chip_en    <= 1'b1;
            mem_address    <= req_addr;
            mem_read_write <= req_write;
            mem_data_in    <= req_wdata;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          mem_chip_en    <= 1'b0;
          mem_read_write <= 1'b0;
          if (mem_read_write) begin
            state <= IDLE;
          end else begin
            lat_cnt <= 3'(RD_LATENCY);
            state   <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (owner) begin
              r1_rdata  <= mem_data_out;
              r1_rvalid <= 1'b1;
            end else begin
              r0_rdata  <= mem_data_out;
              r0_rvalid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3), each with
// its own memory model; directed scenarios plus randomized traffic vs a cycle model.
module tb_mem_port_arbiter;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic       clock = 1'b0;
  logic       rst [2];
  logic       r0_valid [2], r0_write [2], r1_valid [2], r1_write [2];
  logic [7:0] r0_addr [2], r0_wdata [2], r1_addr [2], r1_wdata [2];
  logic       r0_ready [2], r0_rvalid [2], r1_ready [2], r1_rvalid [2];
  logic [7:0] r0_rdata [2], r1_rdata [2];
  logic [7:0] mem_address [2], mem_data_in [2], mem_data_out [2];
  logic       mem_chip_en [2], mem_read_write [2];
  logic [7:0] mem [2][256];
  logic [7:0] pipe [2][4];
  logic       hold0 [2], hold1 [2];
  logic [16:0] prev0 [2], prev1 [2];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    mem_port_arbiter #(.RD_LATENCY(k == 0 ? LAT0 : LAT1)) dut (
      .clock(clock), .reset(rst[k]),
      .r0_valid(r0_valid[k]), .r0_ready(r0_ready[k]), .r0_write(r0_write[k]),
      .r0_addr(r0_addr[k]), .r0_wdata(r0_wdata[k]), .r0_rvalid(r0_rvalid[k]),
      .r0_rdata(r0_rdata[k]),
      .r1_valid(r1_valid[k]), .r1_ready(r1_ready[k]), .r1_write(r1_write[k]),
      .r1_addr(r1_addr[k]), .r1_wdata(r1_wdata[k]), .r1_rvalid(r1_rvalid[k]),
      .r1_rdata(r1_rdata[k]),
      .mem_address(mem_address[k]), .mem_chip_en(mem_chip_en[k]),
      .mem_read_write(mem_read_write[k]), .mem_data_in(mem_data_in[k]),
      .mem_data_out(mem_data_out[k])
    );
  end

  // Memory model: read data appears exactly LAT cycles after the chip_en cycle, garbage otherwise.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= 8'h00;
      end else if (mem_chip_en[k] && mem_read_write[k]) begin
        mem[k][mem_address[k]] <= mem_data_in[k];
      end
      pipe[k][0] <= (mem_chip_en[k] && !mem_read_write[k]) ? mem[k][mem_address[k]] : 8'($urandom);
      for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
    end
  end
  assign mem_data_out[0] = pipe[0][LAT0-1];
  assign mem_data_out[1] = pipe[1][LAT1-1];

  // Requesters must hold their request stable while waiting for ready.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (hold0[k] === 1'b1 && r0_valid[k])
        assert ({r0_write[k], r0_addr[k], r0_wdata[k]} == prev0[k])
          else $error("FAIL req0_stable inst %0d", k);
      if (hold1[k] === 1'b1 && r1_valid[k])
        assert ({r1_write[k], r1_addr[k], r1_wdata[k]} == prev1[k])
          else $error("FAIL req1_stable inst %0d", k);
      hold0[k] <= r0_valid[k] && !r0_ready[k];
      hold1[k] <= r1_valid[k] && !r1_ready[k];
      prev0[k] <= {r0_write[k], r0_addr[k], r0_wdata[k]};
      prev1[k] <= {r1_write[k], r1_addr[k], r1_wdata[k]};
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs(int d);
    r0_valid[d] = 1'b0; r0_write[d] = 1'b0; r0_addr[d] = 8'h00; r0_wdata[d] = 8'h00;
    r1_valid[d] = 1'b0; r1_write[d] = 1'b0; r1_addr[d] = 8'h00; r1_wdata[d] = 8'h00;
  endtask

  task automatic do_reset(int d);
    idle_inputs(d);
    rst[d] = 1'b1;
    step();
    step();
    rst[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] outs;
    r0_valid[0] = 1'b1; r1_valid[0] = 1'b1; rst[0] = 1'b1;
    @(negedge clock);
    checks++;
    if ({r0_ready[0], r1_ready[0]} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", r0_ready[0], r1_ready[0]);
    end
    step();
    @(negedge clock);
    outs = {r0_ready[0], r1_ready[0], r0_rvalid[0], r1_rvalid[0], mem_chip_en[0],
            mem_read_write[0], r0_rdata[0], r1_rdata[0], mem_address[0], mem_data_in[0]};
    checks++;
    if (outs !== 38'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    step();
    rst[0] = 1'b0;
    @(negedge clock);
    checks++;
    if ({r0_ready[0], r1_ready[0]} !== 2'b10) begin
      errors++; $display("FAIL reset_first_grant: got %b%b expected 10", r0_ready[0], r1_ready[0]);
    end
    step();
    r0_valid[0] = 1'b0; r1_valid[0] = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_write();
    r0_valid[0] = 1'b1; r0_write[0] = 1'b1; r0_addr[0] = 8'h10; r0_wdata[0] = 8'hA5;
    @(negedge clock);
    checks++;
    if ({r0_ready[0], r1_ready[0]} !== 2'b10) begin
      errors++; $display("FAIL wr_ready: got %b%b expected 10", r0_ready[0], r1_ready[0]);
    end
    step();
    r0_valid[0] = 1'b0;
    @(negedge clock);
    checks++;
    if ({mem_chip_en[0], mem_read_write[0], mem_address[0], mem_data_in[0]} !== {2'b11, 8'h10, 8'hA5}) begin
      errors++; $display("FAIL wr_issue: got ce=%b rw=%b a=%h d=%h expected ce=1 rw=1 a=10 d=a5",
                         mem_chip_en[0], mem_read_write[0], mem_address[0], mem_data_in[0]);
    end
    step();
    @(negedge clock);
    checks++;
    if ({mem_chip_en[0], mem_read_write[0]} !== 2'b00) begin
      errors++; $display("FAIL wr_release: got ce=%b rw=%b expected 0 0", mem_chip_en[0], mem_read_write[0]);
    end
    step();
  endtask

  task automatic test_read();
    r1_valid[0] = 1'b1; r1_write[0] = 1'b0; r1_addr[0] = 8'h10;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (c == 0) begin
        checks++;
        if ({r0_ready[0], r1_ready[0]} !== 2'b01) begin
          errors++; $display("FAIL rd_ready: got %b%b expected 01", r0_ready[0], r1_ready[0]);
        end
      end
      checks++;
      if ({r0_rvalid[0], r1_rvalid[0]} !== {1'b0, c == 2 + LAT0}) begin
        errors++; $display("FAIL rd_rvalid c=%0d: got %b%b expected 0%b", c, r0_rvalid[0], r1_rvalid[0], c == 2 + LAT0);
      end
      if (c == 2 + LAT0) begin
        checks++;
        if ({r1_rdata[0], r0_rdata[0]} !== {8'hA5, 8'h00}) begin
          errors++; $display("FAIL rd_data: got r1=%h r0=%h expected r1=a5 r0=00", r1_rdata[0], r0_rdata[0]);
        end
      end
      step();
      r1_valid[0] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n1 = 0, o, j;
    logic [7:0] ea, ed;
    r0_valid[0] = 1'b1; r0_write[0] = 1'b1; r0_addr[0] = 8'h20; r0_wdata[0] = 8'h40;
    r1_valid[0] = 1'b1; r1_write[0] = 1'b1; r1_addr[0] = 8'h30; r1_wdata[0] = 8'h50;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      checks++;
      if (mem_chip_en[0] !== (c % 2 == 1)) begin
        errors++; $display("FAIL b2b_ce c=%0d: got %b expected %b", c, mem_chip_en[0], c % 2 == 1);
      end
      if (c % 2 == 0) begin
        o = (c / 2) % 2;
        checks++;
        if ({r0_ready[0], r1_ready[0]} !== {o == 0, o == 1}) begin
          errors++; $display("FAIL b2b_grant c=%0d: got %b%b expected owner %0d", c, r0_ready[0], r1_ready[0], o);
        end
      end else begin
        o = ((c - 1) / 2) % 2;
        j = (c - 1) / 4;
        ea = 8'((o == 0 ? 32'h20 : 32'h30) + j);
        ed = 8'((o == 0 ? 32'h40 : 32'h50) + j);
        checks++;
        if ({mem_read_write[0], mem_address[0], mem_data_in[0]} !== {1'b1, ea, ed}) begin
          errors++; $display("FAIL b2b_issue c=%0d: got rw=%b a=%h d=%h expected rw=1 a=%h d=%h",
                             c, mem_read_write[0], mem_address[0], mem_data_in[0], ea, ed);
        end
      end
      step();
      if (c % 2 == 0) begin
        if (o == 0) begin
          n0++;
          if (n0 == 4) r0_valid[0] = 1'b0;
          else begin r0_addr[0] = 8'(32'h20 + n0); r0_wdata[0] = 8'(32'h40 + n0); end
        end else begin
          n1++;
          if (n1 == 4) r1_valid[0] = 1'b0;
          else begin r1_addr[0] = 8'(32'h30 + n1); r1_wdata[0] = 8'(32'h50 + n1); end
        end
      end
    end
    step();
  endtask

  task automatic test_latency3();
    r0_valid[1] = 1'b1; r0_write[1] = 1'b1; r0_addr[1] = 8'hFF; r0_wdata[1] = 8'h3C;
    @(negedge clock);
    checks++;
    if (r0_ready[1] !== 1'b1) begin
      errors++; $display("FAIL l3_wr_ready: got %b expected 1", r0_ready[1]);
    end
    step();
    r0_valid[1] = 1'b0;
    step();
    step();
    r0_valid[1] = 1'b1; r0_write[1] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      if (c == 0) begin
        checks++;
        if ({r0_ready[1], r1_ready[1]} !== 2'b10) begin
          errors++; $display("FAIL l3_rd_ready: got %b%b expected 10", r0_ready[1], r1_ready[1]);
        end
      end
      if (c == 1) begin
        checks++;
        if ({mem_chip_en[1], mem_read_write[1], mem_address[1]} !== {2'b10, 8'hFF}) begin
          errors++; $display("FAIL l3_issue: got ce=%b rw=%b a=%h expected ce=1 rw=0 a=ff",
                             mem_chip_en[1], mem_read_write[1], mem_address[1]);
        end
      end
      if (c >= 1 && c <= 1 + LAT1) begin
        checks++;
        if (r1_ready[1] !== 1'b0) begin
          errors++; $display("FAIL l3_blocked c=%0d: got r1_ready %b expected 0", c, r1_ready[1]);
        end
      end
      checks++;
      if (r0_rvalid[1] !== (c == 2 + LAT1)) begin
        errors++; $display("FAIL l3_rvalid c=%0d: got %b expected %b", c, r0_rvalid[1], c == 2 + LAT1);
      end
      if (c == 2 + LAT1) begin
        checks++;
        if ({r0_rdata[1], r1_ready[1]} !== {8'h3C, 1'b1}) begin
          errors++; $display("FAIL l3_data: got rdata=%h r1_ready=%b expected rdata=3c r1_ready=1",
                             r0_rdata[1], r1_ready[1]);
        end
      end
      step();
      if (c == 0) begin
        r0_valid[1] = 1'b0;
        r1_valid[1] = 1'b1; r1_write[1] = 1'b1; r1_addr[1] = 8'h44; r1_wdata[1] = 8'h55;
      end
      if (c == 2 + LAT1) r1_valid[1] = 1'b0;
    end
  endtask

  task automatic test_reset_wait_rd();
    r1_valid[1] = 1'b1; r1_write[1] = 1'b0; r1_addr[1] = 8'h44;
    @(negedge clock);
    checks++;
    if ({r0_ready[1], r1_ready[1]} !== 2'b01) begin
      errors++; $display("FAIL abort_ready: got %b%b expected 01", r0_ready[1], r1_ready[1]);
    end
    step();
    r1_valid[1] = 1'b0;
    step();
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    for (int c = 3; c < 9; c++) begin
      @(negedge clock);
      checks++;
      if ({mem_chip_en[1], r1_rvalid[1], r0_rvalid[1]} !== 3'b000) begin
        errors++; $display("FAIL abort_quiet c=%0d: got ce=%b r1v=%b r0v=%b expected 0 0 0",
                           c, mem_chip_en[1], r1_rvalid[1], r0_rvalid[1]);
      end
      step();
    end
    r0_valid[1] = 1'b1; r1_valid[1] = 1'b1; r0_write[1] = 1'b0; r1_write[1] = 1'b0;
    @(negedge clock);
    checks++;
    if ({r0_ready[1], r1_ready[1]} !== 2'b10) begin
      errors++; $display("FAIL abort_next_grant: got %b%b expected 10", r0_ready[1], r1_ready[1]);
    end
    step();
    idle_inputs(1);
    repeat (8) step();
  endtask

  // Cycle-level model built from the latency rules: grants only when the port is free.
  task automatic test_random(int d, int lat, int ncyc);
    logic       v [2], w [2];
    logic [7:0] a [2], wd [2];
    bit         acc [2];
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd [2];
    int         free_at, issue_at, rv_at, win;
    bit         prio, rv_owner, exp_rw;
    logic [7:0] rv_data, exp_addr, exp_din;
    do_reset(d);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int n = 0; n < 2; n++) begin
      v[n] = 1'b0; w[n] = 1'b0; a[n] = 8'h00; wd[n] = 8'h00; acc[n] = 1'b0; last_rd[n] = 8'h00;
    end
    free_at = 0; issue_at = -1; rv_at = -1; prio = 1'b0; rv_owner = 1'b0;
    exp_rw = 1'b0; rv_data = 8'h00; exp_addr = 8'h00; exp_din = 8'h00;
    for (int t = 0; t < ncyc; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (acc[n] || !v[n]) begin
          v[n] = ($urandom_range(0, 99) < 45);
          if (v[n]) begin
            w[n]  = 1'($urandom_range(0, 1));
            a[n]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            wd[n] = 8'($urandom);
          end
        end else if ($urandom_range(0, 99) < 4) begin
          v[n] = 1'b0;
        end
        acc[n] = 1'b0;
      end
      r0_valid[d] = v[0]; r0_write[d] = w[0]; r0_addr[d] = a[0]; r0_wdata[d] = wd[0];
      r1_valid[d] = v[1]; r1_write[d] = w[1]; r1_addr[d] = a[1]; r1_wdata[d] = wd[1];
      @(negedge clock);
      if (t == rv_at) last_rd[rv_owner] = rv_data;
      win = -1;
      if (t >= free_at) begin
        if (v[0] && v[1]) win = prio ? 1 : 0;
        else if (v[0])    win = 0;
        else if (v[1])    win = 1;
      end
      checks++;
      if ({r1_ready[d], r0_ready[d]} !== {win == 1, win == 0}) begin
        errors++; $display("FAIL rnd_ready i%0d t=%0d: got %b%b expected winner %0d", d, t, r1_ready[d], r0_ready[d], win);
      end
      checks++;
      if (t == issue_at) begin
        if ({mem_chip_en[d], mem_read_write[d], mem_address[d], mem_data_in[d]} !== {1'b1, exp_rw, exp_addr, exp_din}) begin
          errors++; $display("FAIL rnd_issue i%0d t=%0d: got ce=%b rw=%b a=%h d=%h expected ce=1 rw=%b a=%h d=%h",
                             d, t, mem_chip_en[d], mem_read_write[d], mem_address[d], mem_data_in[d], exp_rw, exp_addr, exp_din);
        end
      end else if ({mem_chip_en[d], mem_read_write[d]} !== 2'b00) begin
        errors++; $display("FAIL rnd_idle_bus i%0d t=%0d: got ce=%b rw=%b expected 0 0", d, t, mem_chip_en[d], mem_read_write[d]);
      end
      checks++;
      if ({r1_rvalid[d], r0_rvalid[d]} !== {t == rv_at && rv_owner, t == rv_at && !rv_owner}) begin
        errors++; $display("FAIL rnd_rvalid i%0d t=%0d: got %b%b expected due=%0d owner=%0d", d, t, r1_rvalid[d], r0_rvalid[d], rv_at, rv_owner);
      end
      checks++;
      if ({r1_rdata[d], r0_rdata[d]} !== {last_rd[1], last_rd[0]}) begin
        errors++; $display("FAIL rnd_rdata i%0d t=%0d: got r1=%h r0=%h expected r1=%h r0=%h", d, t, r1_rdata[d], r0_rdata[d], last_rd[1], last_rd[0]);
      end
      if (win >= 0) begin
        acc[win] = 1'b1;
        prio     = (win == 0);
        issue_at = t + 1;
        exp_rw   = w[win]; exp_addr = a[win]; exp_din = wd[win];
        if (w[win]) begin
          ref_mem[a[win]] = wd[win];
          free_at = t + 2;
        end else begin
          rv_at    = t + 2 + lat;
          rv_owner = (win == 1);
          rv_data  = ref_mem[a[win]];
          free_at  = t + 2 + lat;
        end
      end
      step();
    end
    idle_inputs(d);
    repeat (8) step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      idle_inputs(k);
    end
    repeat (3) step();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_latency3();
    test_reset_wait_rd();
    test_random(0, LAT0, 400);
    test_random(1, LAT1, 400);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
